// File: rtl/addr_sequencer.sv
// Phase-accumulator address generator: plays one note (increment, length) at a time and
// emits an 11-bit raw waveform address once per sample tick.
module addr_sequencer #(
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned SAMPLE_DIV = 2272,
    parameter int unsigned LEN_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic [PHASE_W-1:0] note_inc,
    input  logic [LEN_W-1:0]   note_len,
    input  logic               stop,
    output logic [10:0]        addr_raw,
    output logic               addr_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_c;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  inc_q, inc_d;
    logic [PHASE_W-1:0]  phase_sum_c;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic [ADDR_W-1:0]   addr_raw_q, addr_raw_d;
    logic                addr_valid_q, addr_valid_d;
    logic                note_ready_q, note_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Free-running sample divider, independent of the note FSM
    always_comb begin
        tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        inc_d        = inc_q;
        remain_d     = remain_q;
        addr_raw_d   = addr_raw_q;
        addr_valid_d = 1'b0;
        phase_sum_c  = phase_q + inc_q;

        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    inc_d      = note_inc;
                    remain_d   = note_len;
                    phase_d    = '0;
                    addr_raw_d = '0;
                    state_d    = (note_len == '0) ? ST_DONE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Abort wins over a coincident tick: no address update on the stop cycle
                if (stop) begin
                    state_d = ST_DONE;
                end else if (tick_c) begin
                    phase_d      = phase_sum_c;
                    addr_raw_d   = phase_sum_c[PHASE_W-1 -: ADDR_W];
                    addr_valid_d = 1'b1;
                    remain_d     = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        note_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            phase_q      <= '0;
            inc_q        <= '0;
            remain_q     <= '0;
            addr_raw_q   <= '0;
            addr_valid_q <= 1'b0;
            note_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            inc_q        <= inc_d;
            remain_q     <= remain_d;
            addr_raw_q   <= addr_raw_d;
            addr_valid_q <= addr_valid_d;
            note_ready_q <= note_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign note_ready = note_ready_q;
    assign addr_raw   = addr_raw_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for addr_sequencer with PHASE_W=16, SAMPLE_DIV=4.
module tb_addr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        note_valid;
    logic        note_ready;
    logic [15:0] note_inc;
    logic [15:0] note_len;
    logic        stop;
    logic [10:0] addr_raw;
    logic        addr_valid;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    int          s_cnt;
    logic [10:0] s_addr [16];
    int          s_gap  [16];
    logic        d_av;
    logic [10:0] d_addr;

    addr_sequencer #(
        .PHASE_W    (16),
        .SAMPLE_DIV (4),
        .LEN_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_inc   (note_inc),
        .note_len   (note_len),
        .stop       (stop),
        .addr_raw   (addr_raw),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one note, follow it to its done cycle, then check the return to idle
    task automatic run_note(input logic [15:0] inc, input logic [15:0] len,
                            input int stop_after, input bit offer_mid);
        int since;
        int last;
        bit seen;
        s_cnt    = 0;
        since    = 0;
        last     = 0;
        seen     = 1'b0;
        d_av     = 1'b0;
        d_addr   = '0;
        chk("pre_accept_ready", 32'(note_ready), 32'd1);
        note_inc   = inc;
        note_len   = len;
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
        chk("accept_ready", 32'(note_ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 200 && !seen; c++) begin
            if (addr_valid) begin
                if (s_cnt < 16) begin
                    s_addr[s_cnt] = addr_raw;
                    s_gap[s_cnt]  = c - last;
                end
                last  = c;
                s_cnt = s_cnt + 1;
                since = 0;
                if (offer_mid && s_cnt == 1) begin
                    note_inc   = 16'h1000;
                    note_len   = 16'd1;
                    note_valid = 1'b1;
                end
            end else begin
                since = since + 1;
            end
            if (done) begin
                seen       = 1'b1;
                d_av       = addr_valid;
                d_addr     = addr_raw;
                note_valid = 1'b0;
                stop       = 1'b0;
            end else begin
                stop = (stop_after > 0 && s_cnt == stop_after && since == 3);
                @(negedge clk);
            end
        end
        if (!seen) chk("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
        chk("post_ready", 32'(note_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_valid", 32'(addr_valid), 32'd0);
    endtask

    initial begin
        int done_cnt;
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        note_valid = 1'b0;
        note_inc   = '0;
        note_len   = '0;
        stop       = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(note_ready), 32'd1);
        chk("rst_addr", 32'(addr_raw), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(note_ready), 32'd1);
        chk("idle_valid", 32'(addr_valid), 32'd0);

        // Linear ramp
        run_note(16'd32, 16'd3, 0, 1'b0);
        chk("ramp_cnt", 32'(s_cnt), 32'd3);
        chk("ramp_a0", 32'(s_addr[0]), 32'd1);
        chk("ramp_a1", 32'(s_addr[1]), 32'd2);
        chk("ramp_a2", 32'(s_addr[2]), 32'd3);
        chk("ramp_gap1", 32'(s_gap[1]), 32'd4);
        chk("ramp_gap2", 32'(s_gap[2]), 32'd4);
        chk("ramp_done_valid", 32'(d_av), 32'd1);
        chk("ramp_done_addr", 32'(d_addr), 32'd3);

        // Half-boundary toggle and accumulator wrap
        run_note(16'h4000, 16'd5, 0, 1'b0);
        chk("wrap_cnt", 32'(s_cnt), 32'd5);
        chk("wrap_a0", 32'(s_addr[0]), 32'd512);
        chk("wrap_a1", 32'(s_addr[1]), 32'd1024);
        chk("wrap_a2", 32'(s_addr[2]), 32'd1536);
        chk("wrap_a3", 32'(s_addr[3]), 32'd0);
        chk("wrap_a4", 32'(s_addr[4]), 32'd512);
        chk("wrap_gap4", 32'(s_gap[4]), 32'd4);
        chk("wrap_done_valid", 32'(d_av), 32'd1);

        // Zero-length note: done right after accept, address cleared
        run_note(16'd100, 16'd0, 0, 1'b0);
        chk("zero_cnt", 32'(s_cnt), 32'd0);
        chk("zero_done_valid", 32'(d_av), 32'd0);
        chk("zero_done_addr", 32'(d_addr), 32'd0);
        chk("zero_addr_after", 32'(addr_raw), 32'd0);

        // Abort on a tick cycle after two strobes
        run_note(16'h8000, 16'd10, 2, 1'b0);
        chk("abort_cnt", 32'(s_cnt), 32'd2);
        chk("abort_a0", 32'(s_addr[0]), 32'h400);
        chk("abort_a1", 32'(s_addr[1]), 32'd0);
        chk("abort_done_valid", 32'(d_av), 32'd0);
        chk("abort_done_addr", 32'(d_addr), 32'd0);
        chk("abort_addr_after", 32'(addr_raw), 32'd0);

        // Second note offered during PLAY is ignored
        run_note(16'd32, 16'd2, 0, 1'b1);
        chk("mid_cnt", 32'(s_cnt), 32'd2);
        chk("mid_a0", 32'(s_addr[0]), 32'd1);
        chk("mid_a1", 32'(s_addr[1]), 32'd2);

        // Re-offered after DONE: accepted with phase restarted
        run_note(16'h1000, 16'd1, 0, 1'b0);
        chk("reoffer_cnt", 32'(s_cnt), 32'd1);
        chk("reoffer_a0", 32'(s_addr[0]), 32'd128);
        chk("reoffer_done_valid", 32'(d_av), 32'd1);

        // Reset mid-note
        note_inc   = 16'd32;
        note_len   = 16'd10;
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(note_ready), 32'd1);
        chk("mid_rst_addr", 32'(addr_raw), 32'd0);
        chk("mid_rst_valid", 32'(addr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        chk("mid_rst_idle_ready", 32'(note_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
